// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU memory responder.
// The boot loader FSM is either streaming program bytes in or serving the CPU.
package mem_pkg;
  typedef enum logic {LOAD, RUN} load_state_t;
  localparam int IMEM_BYTES_PER_WORD = 2;
endpackage

// File: rtl/dmem.sv
// Data memory: combinational read, synchronous write.
// Contents are deliberately not reset so stored data survives a reset.
module dmem
  import mem_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [DWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);
  logic [DWIDTH-1:0] mem_q [2**DWIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: boot-loads instruction memory from a byte stream while
// holding the CPU in reset, then serves instruction fetches and data loads/stores.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cpu_reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [DWIDTH:0]   words_loaded,
  input  logic [DWIDTH-1:0] pc,
  output logic [IWIDTH-1:0] instr,
  input  logic              memwrite,
  input  logic [DWIDTH-1:0] aluout,
  input  logic [DWIDTH-1:0] writedata,
  output logic [DWIDTH-1:0] readdata
);
  localparam int DEPTH  = 2**DWIDTH;
  localparam int BYTE_W = IWIDTH / IMEM_BYTES_PER_WORD;

  load_state_t       state_q, state_d;
  logic [DWIDTH-1:0] load_addr_q, load_addr_d;
  logic              hi_valid_q, hi_valid_d;
  logic [BYTE_W-1:0] hi_byte_q, hi_byte_d;
  logic [DWIDTH:0]   words_q, words_d;
  logic              cpu_reset_q, load_ready_q;
  logic              accept;
  logic              imem_we;
  logic [IWIDTH-1:0] imem_wdata;
  logic [IWIDTH-1:0] imem_q [DEPTH];
  logic [DWIDTH-1:0] dmem_rdata;

  assign accept = (state_q == LOAD) && load_valid && load_ready_q;

  // A last byte arriving as a high byte is padded with a zero low byte.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    hi_valid_d  = hi_valid_q;
    hi_byte_d   = hi_byte_q;
    words_d     = words_q;
    imem_we     = 1'b0;
    imem_wdata  = {hi_byte_q, load_data};
    if (accept) begin
      if (!hi_valid_q && !load_last) begin
        hi_byte_d  = load_data;
        hi_valid_d = 1'b1;
      end else begin
        imem_we     = 1'b1;
        imem_wdata  = hi_valid_q ? {hi_byte_q, load_data} : {load_data, 8'h00};
        load_addr_d = load_addr_q + 1'b1;
        words_d     = words_q + 1'b1;
        hi_valid_d  = 1'b0;
        if (load_last || (load_addr_q == '1)) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      load_addr_q  <= '0;
      hi_valid_q   <= 1'b0;
      hi_byte_q    <= '0;
      words_q      <= '0;
      cpu_reset_q  <= 1'b1;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      load_addr_q  <= load_addr_d;
      hi_valid_q   <= hi_valid_d;
      hi_byte_q    <= hi_byte_d;
      words_q      <= words_d;
      cpu_reset_q  <= (state_d == LOAD);
      load_ready_q <= (state_d == LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we && !reset) imem_q[load_addr_q] <= imem_wdata;
  end

  dmem #(.DWIDTH(DWIDTH)) u_dmem (
    .clk     (clk),
    .we_i    (memwrite && (state_q == RUN)),
    .addr_i  (aluout),
    .wdata_i (writedata),
    .rdata_o (dmem_rdata)
  );

  assign cpu_reset    = cpu_reset_q;
  assign load_ready   = load_ready_q;
  assign words_loaded = words_q;
  assign instr        = (state_q == RUN) ? imem_q[pc] : '0;
  assign readdata     = (state_q == RUN) ? dmem_rdata : '0;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: streams randomized programs and data traffic
// and compares against a byte-list / array model of the loader and data memory.
module tb_mem_responder;
  localparam int DWIDTH = 8;
  localparam int IWIDTH = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_reset;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic [DWIDTH:0]   words_loaded;
  logic [DWIDTH-1:0] pc;
  logic [IWIDTH-1:0] instr;
  logic              memwrite;
  logic [DWIDTH-1:0] aluout;
  logic [DWIDTH-1:0] writedata;
  logic [DWIDTH-1:0] readdata;

  int          checks = 0;
  int          errors = 0;
  byte unsigned progBytes[$];
  logic [7:0]  dmemModel [DEPTH];
  bit          dmemKnown [DEPTH];

  mem_responder #(.DWIDTH(DWIDTH), .IWIDTH(IWIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_reset    (cpu_reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .words_loaded (words_loaded),
    .pc           (pc),
    .instr        (instr),
    .memwrite     (memwrite),
    .aluout       (aluout),
    .writedata    (writedata),
    .readdata     (readdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives the loader port and scrambles every other input, which must be ignored in LOAD.
  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last);
    load_valid = valid;
    load_data  = data;
    load_last  = last;
    pc         = 8'($urandom_range(0, 255));
    aluout     = 8'($urandom_range(0, 255));
    writedata  = 8'($urandom_range(0, 255));
    memwrite   = 1'($urandom_range(0, 1));
  endtask

  // Program word k is bytes 2k (high) and 2k+1 (low), with a missing low byte read as zero.
  function automatic logic [15:0] expWord(input int k);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = progBytes[2*k];
    lo = (2*k + 1 < progBytes.size()) ? progBytes[2*k+1] : 8'h00;
    return {hi, lo};
  endfunction

  task automatic doReset;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    memwrite   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rstCpuReset", 32'(cpu_reset), 1);
    checkOutput("rstLoadReady", 32'(load_ready), 1);
    checkOutput("rstWords", 32'(words_loaded), 0);
    checkOutput("rstInstr", 32'(instr), 0);
    checkOutput("rstReaddata", 32'(readdata), 0);
  endtask

  task automatic randomProgram(input int n);
    progBytes.delete();
    for (int i = 0; i < n; i++) progBytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic streamProgram(input bit useLast, input int gapMax, input bit expectRun);
    int n;
    n = progBytes.size();
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
      repeat (gaps) begin
        applyStimulus(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        #1;
        checkOutput("gapWords", 32'(words_loaded), 32'(i / 2));
        tick();
      end
      applyStimulus(1'b1, progBytes[i], useLast && (i == n - 1));
      #1;
      checkOutput("loadReady", 32'(load_ready), 1);
      checkOutput("loadCpuReset", 32'(cpu_reset), 1);
      checkOutput("loadInstr", 32'(instr), 0);
      checkOutput("loadReaddata", 32'(readdata), 0);
      checkOutput("loadWords", 32'(words_loaded), 32'(i / 2));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    memwrite = 1'b0;
    #1;
    if (expectRun) begin
      checkOutput("runCpuReset", 32'(cpu_reset), 0);
      checkOutput("runLoadReady", 32'(load_ready), 0);
      checkOutput("runWords", 32'(words_loaded), 32'((n + 1) / 2));
    end else begin
      checkOutput("stillCpuReset", 32'(cpu_reset), 1);
      checkOutput("stillLoadReady", 32'(load_ready), 1);
      checkOutput("stillWords", 32'(words_loaded), 32'(n / 2));
    end
  endtask

  // Loader traffic keeps arriving during fetches; in RUN it must change nothing.
  task automatic fetchAll(input int nWords);
    logic [DWIDTH:0] wordsBefore;
    wordsBefore = words_loaded;
    for (int k = 0; k < nWords; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      pc       = 8'(k);
      memwrite = 1'b0;
      #1;
      checkOutput($sformatf("instr[%0d]", k), 32'(instr), 32'(expWord(k)));
      tick();
    end
    load_valid = 1'b0;
    #1;
    checkOutput("fetchWords", 32'(words_loaded), 32'(wordsBefore));
    checkOutput("fetchCpuReset", 32'(cpu_reset), 0);
  endtask

  task automatic dataOps(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      logic [7:0] addr;
      logic       we;
      logic [7:0] wd;
      addr = 8'($urandom_range(0, 31));
      we   = 1'($urandom_range(0, 1));
      wd   = 8'($urandom_range(0, 255));
      aluout    = addr;
      memwrite  = we;
      writedata = wd;
      #1;
      if (dmemKnown[addr]) checkOutput("readOld", 32'(readdata), 32'(dmemModel[addr]));
      tick();
      if (we) begin
        dmemModel[addr] = wd;
        dmemKnown[addr] = 1'b1;
      end
    end
    memwrite = 1'b0;
  endtask

  task automatic readBack;
    memwrite = 1'b0;
    for (int a = 0; a < 32; a++) begin
      aluout = 8'(a);
      #1;
      if (dmemKnown[a]) checkOutput($sformatf("readBack[%0d]", a), 32'(readdata), 32'(dmemModel[a]));
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    pc         = '0;
    memwrite   = 1'b0;
    aluout     = '0;
    writedata  = '0;

    doReset();
    progBytes = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    streamProgram(1'b1, 0, 1'b1);
    fetchAll(3);

    aluout    = 8'h10;
    writedata = 8'hA5;
    memwrite  = 1'b1;
    tick();
    memwrite = 1'b0;
    #1;
    checkOutput("storeVisible", 32'(readdata), 32'hA5);
    dmemModel[8'h10] = 8'hA5;
    dmemKnown[8'h10] = 1'b1;
    for (int a = 0; a < 32; a++) begin
      if (a != 8'h10) begin
        aluout    = 8'(a);
        writedata = 8'($urandom_range(0, 255));
        memwrite  = 1'b1;
        tick();
        dmemModel[a] = writedata;
        dmemKnown[a] = 1'b1;
      end
    end
    memwrite = 1'b0;
    dataOps(60);

    doReset();
    progBytes = {8'hAB, 8'hCD};
    streamProgram(1'b1, 3, 1'b1);
    fetchAll(1);
    readBack();

    doReset();
    progBytes = {8'h11, 8'h22, 8'h33};
    streamProgram(1'b1, 2, 1'b1);
    fetchAll(2);

    doReset();
    randomProgram(512);
    streamProgram(1'b0, 0, 1'b1);
    fetchAll(256);

    doReset();
    randomProgram(37);
    streamProgram(1'b1, 2, 1'b1);
    fetchAll(19);

    doReset();
    randomProgram(3);
    streamProgram(1'b0, 1, 1'b0);
    doReset();
    progBytes = {8'hDE, 8'hAD};
    streamProgram(1'b1, 0, 1'b1);
    fetchAll(1);
    readBack();
    dataOps(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the single-cycle CPU's fetch and data ports. It holds a 16-bit instruction memory and an 8-bit data memory. After reset it runs a byte-stream boot loader that fills instruction memory while the CPU is held in reset, then releases the CPU and serves fetches and loads/stores. It sits between the top-level test harness or host link and the `cpu` instance.

## Interface
Parameters:
- `DWIDTH`, 8: data and address width; both memories have 2**DWIDTH entries.
- `IWIDTH`, 16: instruction width; fixed at 2 bytes per instruction.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `cpu_reset`  out  1: reset driven to the CPU; high while loading.
- `load_valid`  in  1: loader byte valid.
- `load_data`  in  8: loader byte; high byte of each instruction is sent first.
- `load_last`  in  1: marks the final byte of the program; qualified by `load_valid`.
- `load_ready`  out  1: the loader accepts a byte.
- `words_loaded`  out  DWIDTH+1: count of instruction words written in the current load.
- `pc`  in  DWIDTH: fetch address from the CPU.
- `instr`  out  IWIDTH: fetched instruction.
- `memwrite`  in  1: data store enable.
- `aluout`  in  DWIDTH: data address.
- `writedata`  in  DWIDTH: store data.
- `readdata`  out  DWIDTH: load data.

## Operation
- FSM has two states, LOAD and RUN. `reset` forces LOAD with `load_addr`=0, `hi_valid`=0 and `words_loaded`=0.
- **LOAD state**
  - `load_ready`=1 and `cpu_reset`=1. `instr` is forced to 0 and `readdata` is forced to 0.
  - A byte is accepted on a posedge where `load_valid && load_ready`.
  - If `hi_valid`=0: latch `hi_byte`, then set `hi_valid`=1.
  - If `hi_valid`=1: write `imem[load_addr] = {hi_byte, load_data}`, increment `load_addr` and `words_loaded`, then clear `hi_valid`.
  - `load_last` accepted with a low byte: write that word, then go to RUN.
  - `load_last` accepted with a high byte: write `{load_data, 8'h00}`, increment the address and count, then go to RUN.
  - Writing word index 2**DWIDTH-1 without `load_last`: go to RUN anyway. `words_loaded` is then 2**DWIDTH; the address wrap is never used.
  - `memwrite` is ignored in LOAD.
- **RUN state**
  - `load_ready`=0 and `cpu_reset`=0. Loader inputs are ignored.
  - `instr = imem[pc]`, combinational.
  - `readdata = dmem[aluout]`, combinational.
  - `dmem[aluout] <= writedata` at a posedge with `memwrite`=1.
- RUN persists until `reset`. There is no return path to LOAD except `reset`.
- Memory contents are not cleared by reset.
  - `imem` words not written in the current load are unspecified; the bench must not fetch them.
  - `dmem` contents survive reset.

## Timing
- Reset values: `cpu_reset`=1, `load_ready`=1, `words_loaded`=0, `instr`=0, `readdata`=0.
- `cpu_reset` and `load_ready` are registered, decoded from the state register.
  - They deassert the cycle after the posedge that accepts the final byte.
  - The CPU's first fetch of `pc`=0 happens in that cycle.
- Store-to-load latency: a store at posedge N is visible on `readdata` from N+ (same address, combinational read after the write).
- Read and write to the same address in the same cycle: `readdata` shows old data until the edge.
- `reset` mid-load: a half-received word (`hi_valid`=1) is discarded. Words already written remain in `imem` but are unspecified for the next load.
- `reset` asserted in the same cycle as the last byte: `reset` wins and the state stays LOAD. Whether that word is written is unspecified.
- Back-to-back bytes are accepted every cycle. `load_valid` gaps cause no writes.

## Structure
- Package `mem_pkg` holds:
  - `typedef enum logic {LOAD, RUN} load_state_t`.
  - `IMEM_BYTES_PER_WORD = 2`.
- Sub-module `dmem`: 2**DWIDTH x DWIDTH RAM with combinational read and synchronous write, gated by `memwrite && state==RUN`.
- The `imem` array, byte assembler and FSM are inline in `mem_responder`.

## Test plan
- **Basic load and fetch**: reset, then stream bytes 12 34 56 78 9A BC with `load_last` on BC.
  - Response: `load_ready` falls and `cpu_reset` falls the next cycle; `words_loaded`=3.
  - `pc`=0/1/2 gives `instr` 0x1234/0x5678/0x9ABC.
- **Load with gaps**: `load_valid` toggles 1,0,0,1.
  - Response: only 2 bytes accepted, 1 word 0xAB CD written, `words_loaded`=1. No extra writes.
- **Odd-length program**: 3 bytes 11 22 33 with `load_last` on 33.
  - Response: `imem[1]`=0x3300, `words_loaded`=2, RUN entered.
- **Full memory load**: 512 bytes, no `load_last`.
  - Response: auto RUN after byte 512, `words_loaded`=256, `imem[255]` correct.
- **Data port in RUN**: `aluout`=0x10, `writedata`=0xA5, `memwrite`=1 for one cycle.
  - Response: then `readdata`=0xA5 at 0x10.
  - Same stimulus during LOAD leaves `dmem[0x10]` unchanged and `readdata`=0.
- **Reset mid-load**: `reset` after 3 bytes.
  - Response: `words_loaded`=0, `cpu_reset`=1.
  - Reload 0xDEAD with `load_last` gives `imem[0]`=0xDEAD.
